// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional early-out path for trivial operands is enabled by defining MULDIV_BYPASS_EN.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic             kill_i,
   input  logic [WIDTH-1:0] A_i,
   input  logic [WIDTH-1:0] B_i,
   output logic [WIDTH-1:0] result_o,
   output logic             done_o,
   output logic             busy_o
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state, state_nx;
   logic [2:0]         op_q;
   logic [WIDTH-1:0]   a_mag, b_mag, quot;
   logic [WIDTH:0]     rem;
   logic               sign_a, sign_b;
   logic [CW-1:0]      cnt;

   logic               a_signed, b_signed, sa_in, sb_in, byp;
   logic [WIDTH-1:0]   a_abs, b_abs, addend;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] product, prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix, result_nx;

   assign a_signed = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
   assign b_signed = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
   assign sa_in    = a_signed && A_i[WIDTH-1];
   assign sb_in    = b_signed && B_i[WIDTH-1];
   assign a_abs    = sa_in ? -A_i : A_i;
   assign b_abs    = sb_in ? -B_i : B_i;

`ifdef MULDIV_BYPASS_EN
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
   logic ovf;
   assign ovf = ((op_i == 3'b100) || (op_i == 3'b110)) && (A_i == MIN_VAL) && (B_i == '1);
   assign byp = op_i[2] ? ((B_i == '0) || ovf) : ((A_i == '0) || (B_i == '0));
`else
   assign byp = 1'b0;
`endif

   // rem[WIDTH] stays zero while multiplying, so summing the full register is exact
   assign addend    = quot[0] ? a_mag : '0;
   assign mul_sum   = rem + {1'b0, addend};
   assign div_shift = {rem[WIDTH-1:0], quot[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, b_mag};

   assign product  = {rem[WIDTH-1:0], quot};
   assign prod_fix = (sign_a ^ sign_b) ? -product : product;
   assign quot_fix = ((sign_a ^ sign_b) && (b_mag != '0)) ? -quot : quot;
   assign rem_fix  = sign_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

   always_comb begin
      result_nx = rem_fix;
      case (op_q)
         3'b000:                 result_nx = prod_fix[WIDTH-1:0];
         3'b001, 3'b010, 3'b011: result_nx = prod_fix[2*WIDTH-1:WIDTH];
         3'b100, 3'b101:         result_nx = quot_fix;
         default:                result_nx = rem_fix;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start_i && !kill_i) state_nx = byp ? FIX : CALC;
         CALC: begin
            if (kill_i)              state_nx = IDLE;
            else if (cnt == '0)      state_nx = FIX;
         end
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q     <= '0;
         a_mag    <= '0;
         b_mag    <= '0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         cnt      <= '0;
         rem      <= '0;
         quot     <= '0;
         result_o <= '0;
         done_o   <= 1'b0;
         busy_o   <= 1'b0;
      end else begin
         done_o <= (state == FIX) && !kill_i;
         busy_o <= (state_nx != IDLE);
         case (state)
            IDLE: begin
               if (start_i && !kill_i) begin
                  op_q   <= op_i;
                  a_mag  <= a_abs;
                  b_mag  <= b_abs;
                  sign_a <= sa_in;
                  sign_b <= sb_in;
                  cnt    <= CW'(WIDTH - 1);
                  rem    <= '0;
                  quot   <= op_i[2] ? a_abs : b_abs;
`ifdef MULDIV_BYPASS_EN
                  // preload the registers with what CALC would have produced
                  if (byp) begin
                     if (!op_i[2]) begin
                        quot <= '0;
                     end else if (B_i == '0) begin
                        rem  <= {1'b0, a_abs};
                        quot <= '1;
                     end
                  end
`endif
               end
            end
            CALC: begin
               if (!kill_i) begin
                  cnt <= cnt - CW'(1);
                  if (op_q[2]) begin
                     if (!div_diff[WIDTH]) begin
                        rem  <= div_diff;
                        quot <= {quot[WIDTH-2:0], 1'b1};
                     end else begin
                        rem  <= div_shift;
                        quot <= {quot[WIDTH-2:0], 1'b0};
                     end
                  end else begin
                     rem  <= {1'b0, mul_sum[WIDTH:1]};
                     quot <= {mul_sum[0], quot[WIDTH-1:1]};
                  end
               end
            end
            FIX: begin
               if (!kill_i) result_o <= result_nx;
            end
            default: ;
         endcase
      end
   end

endmodule
